aes_decipher_sched: RTL and testbench

AES_DECIPHER_SCHED -- requirements
Module: aes_decipher_sched

---
 rtl/aes_decipher_sched_pkg.sv | 14 +
 rtl/aes_decipher_sched_rr_arb2.sv | 17 +
 rtl/aes_decipher_sched.sv | 160 ++++++++++++++++
 tb/tb_aes_decipher_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decipher_sched_pkg.sv
// Shared types and constants for the AES decipher scheduler.
package aes_decipher_sched_pkg;

  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned NUM_ROUNDS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_RESP
  } sched_state_e;

endpackage

// File: rtl/aes_decipher_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_decipher_sched.sv
// Two-requester scheduler in front of an iterative AES decipher core.
// Optional run watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_decipher_sched
  import aes_decipher_sched_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS     = NUM_ROUNDS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [AES_BLOCK_W-1:0] req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [AES_BLOCK_W-1:0] req1_data,
  output logic                   core_start,
  output logic [AES_BLOCK_W-1:0] core_cipher,
  output logic [3:0]             key_idx,
  input  logic                   core_done,
  input  logic [AES_BLOCK_W-1:0] core_plain,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [AES_BLOCK_W-1:0] rsp_data,
  output logic                   rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam logic [3:0] KEY_LAST  = 4'(NUM_ROUNDS);
  localparam logic [3:0] KEY_FIRST = 4'(NUM_ROUNDS - 1);

  sched_state_e           state_q, state_d;
  logic [AES_BLOCK_W-1:0] cipher_q, cipher_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic                   id_q, id_d;
  logic                   last_q, last_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [1:0]             gnt;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cipher_q <= '0;
      data_q   <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      rnd_q    <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cipher_q <= cipher_d;
      data_q   <= data_d;
      id_q     <= id_d;
      last_q   <= last_d;
      rnd_q    <= rnd_d;
`ifdef AES_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cipher_d   = cipher_q;
    data_d     = data_q;
    id_d       = id_q;
    last_d     = last_q;
    rnd_d      = rnd_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_start = 1'b0;
    key_idx    = '0;
`ifdef AES_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          req0_ready = gnt[0];
          req1_ready = gnt[1];
          cipher_d   = gnt[0] ? req0_data : req1_data;
          id_d       = gnt[1];
          last_d     = gnt[1];
          state_d    = ST_START;
        end
      end
      ST_START: begin
        core_start = 1'b1;
        key_idx    = KEY_LAST;
        rnd_d      = KEY_FIRST;
`ifdef AES_SCHED_TIMEOUT_EN
        cnt_d      = '0;
`endif
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        key_idx = rnd_q;
        if (rnd_q != '0) begin
          rnd_d = rnd_q - 4'd1;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (core_done) begin
          data_d  = core_plain;
`ifdef AES_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        // cnt_q counts completed RUN cycles; this is the last one allowed
        else if (cnt_q == CNT_LIMIT) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_cipher = cipher_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = data_q;
  assign rsp_id      = id_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef AES_SCHED_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Directed self-checking bench for aes_decipher_sched (NUM_ROUNDS=10, TIMEOUT_CYCLES=24).
module tb_aes_decipher_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data, req1_data;
  logic         core_start;
  logic [127:0] core_cipher;
  logic [3:0]   key_idx;
  logic         core_done;
  logic [127:0] core_plain;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id, rsp_err, busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  aes_decipher_sched #(
    .NUM_ROUNDS     (10),
    .TIMEOUT_CYCLES (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .core_start  (core_start),
    .core_cipher (core_cipher),
    .key_idx     (key_idx),
    .core_done   (core_done),
    .core_plain  (core_plain),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction starting at a negedge in IDLE.
  task automatic do_block(input logic v0, input logic v1,
                          input logic [127:0] d0, input logic [127:0] d1,
                          input logic exp_id, input logic [127:0] plain,
                          input int extra, input int hold);
    logic [127:0] exp_c;
    exp_c = exp_id ? d1 : d0;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    #1;
    check_eq("acc_ready0", req0_ready, !exp_id);
    check_eq("acc_ready1", req1_ready, exp_id);
    @(negedge clk); #1;
    check_eq("start_pulse", core_start, 1'b1);
    check_eq("start_key", key_idx, 4'd10);
    check_eq("start_cipher", core_cipher, exp_c);
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_ready", {req1_ready, req0_ready}, 2'b00);
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk); #1;
      check_eq("run_key", key_idx, k);
      check_eq("run_nostart", core_start, 1'b0);
      if (k == 0 && extra == 0) begin
        core_done  = 1'b1;
        core_plain = plain;
      end
    end
    for (int e = 0; e < extra; e++) begin
      @(negedge clk); #1;
      check_eq("run_key_sat", key_idx, 4'd0);
      if (e == extra - 1) begin
        core_done  = 1'b1;
        core_plain = plain;
      end
    end
    @(negedge clk);
    core_done  = 1'b0;
    core_plain = '0;
    #1;
    check_eq("rsp_valid", rsp_valid, 1'b1);
    check_eq("rsp_data", rsp_data, plain);
    check_eq("rsp_id", rsp_id, exp_id);
    check_eq("rsp_err", rsp_err, 1'b0);
    check_eq("rsp_cipher_hold", core_cipher, exp_c);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check_eq("hold_valid", rsp_valid, 1'b1);
      check_eq("hold_data", rsp_data, plain);
      check_eq("hold_ready", {req1_ready, req0_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("hs_ready", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check_eq("post_valid", rsp_valid, 1'b0);
    check_eq("post_busy", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    core_done  = 1'b0;
    core_plain = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", {req1_ready, req0_ready}, 2'b00);
    check_eq("rst_start", core_start, 1'b0);
    check_eq("rst_cipher", core_cipher, '0);
    check_eq("rst_key", key_idx, 4'd0);
    check_eq("rst_valid", rsp_valid, 1'b0);
    check_eq("rst_data", rsp_data, '0);
    check_eq("rst_id", rsp_id, 1'b0);
    check_eq("rst_err", rsp_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);

    // FIPS-197 vector, with two extra RUN cycles to exercise counter saturation
    do_block(1'b1, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h0,
             1'b0, 128'h00112233445566778899aabbccddeeff, 2, 0);
    req0_valid = 1'b0;

    // reset in RUN cycle 4
    req0_valid = 1'b1;
    req0_data  = 128'hdeadbeef_00000000_cafef00d_12345678;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("mid_run_key", key_idx, 4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstrun_busy", busy, 1'b0);
    check_eq("rstrun_valid", rsp_valid, 1'b0);
    check_eq("rstrun_key", key_idx, 4'd0);
    check_eq("rstrun_cipher", core_cipher, '0);

    // stray core_done in IDLE
    core_done  = 1'b1;
    core_plain = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    @(negedge clk);
    core_done  = 1'b0;
    core_plain = '0;
    #1;
    check_eq("idle_done_busy", busy, 1'b0);
    check_eq("idle_done_valid", rsp_valid, 1'b0);
    check_eq("idle_done_data", rsp_data, '0);
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("idle_quiet", rsp_valid, 1'b0);
    end

    // three back-to-back ties after reset: 0,1,0
    do_block(1'b1, 1'b1, 128'h0a0a0a0a_0a0a0a0a_0a0a0a0a_0a0a0a0a,
             128'h1b1b1b1b_1b1b1b1b_1b1b1b1b_1b1b1b1b, 1'b0, 128'h11, 0, 0);
    do_block(1'b1, 1'b1, 128'h0a0a0a0a_0a0a0a0a_0a0a0a0a_0a0a0a0a,
             128'h1b1b1b1b_1b1b1b1b_1b1b1b1b_1b1b1b1b, 1'b1, 128'h22, 0, 0);
    do_block(1'b1, 1'b1, 128'h0c0c0c0c_0c0c0c0c_0c0c0c0c_0c0c0c0c,
             128'h1d1d1d1d_1d1d1d1d_1d1d1d1d_1d1d1d1d, 1'b0, 128'h33, 0, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // lone requester 0 wins although pointer favours 1; stalled response
    do_block(1'b1, 1'b0, 128'h0123456789abcdef_fedcba9876543210, 128'h0,
             1'b0, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa, 0, 5);
    req0_valid = 1'b0;
    do_block(1'b0, 1'b1, 128'h0, 128'h13579bdf_2468ace0_13579bdf_2468ace0,
             1'b1, 128'hc3c3c3c3_3c3c3c3c_c3c3c3c3_3c3c3c3c, 0, 1);
    req1_valid = 1'b0;

    // RUN with no core_done
    req0_valid = 1'b1;
    req0_data  = 128'h77;
    #1;
    check_eq("to_acc", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    cyc = 0;
    #1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
`ifdef AES_SCHED_TIMEOUT_EN
    check_eq("to_cycles", cyc, 25);
    check_eq("to_valid", rsp_valid, 1'b1);
    check_eq("to_err", rsp_err, 1'b1);
    check_eq("to_data", rsp_data, '0);
`else
    check_eq("nto_cycles", cyc, 40);
    check_eq("nto_valid", rsp_valid, 1'b0);
    check_eq("nto_busy", busy, 1'b1);
    core_done  = 1'b1;
    core_plain = 128'h99;
    @(negedge clk);
    core_done  = 1'b0;
    #1;
    check_eq("nto_rsp", rsp_valid, 1'b1);
    check_eq("nto_data", rsp_data, 128'h99);
    check_eq("nto_err", rsp_err, 1'b0);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check_eq("to_post_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
